simt_alu_pipe: RTL and testbench
================================

Name: simt_alu_pipe

Overview:
- Parametrised, pipelined successor to the per-warp lane ALU.
- Computes one warp instruction across LANES lanes of LANE_W bits each, with a 4-bit opcode space that adds XOR, shift and MIN/MAX operations.
- Has a 2-stage valid/ready pipeline with output backpressure, signed saturation on ADD and SUB, and a sticky error flag.
- Sits between the warp scheduler/operand collector and the register-file writeback.

Parameters:
- LANES, 4, number of lanes per warp (≥1)
- LANE_W, 8, bits per lane (power of two, 8..32)
- WID_W, 5, warp-id width
- SH_W, $clog2(LANE_W), derived shift-amount width; not overridable

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  instruction presented
- in_ready  out  1  pipeline accepts this cycle
- opcode  in  4  operation, see Behaviour
- mask_en  in  1  1: apply lane_mask; 0: all lanes
- lane_mask  in  LANES  lane enable
- pred  in  LANES  per-lane predicate, ANDed with the effective mask
- srcA, srcB  in  LANES*LANE_W  packed lane operands, lane i at [i*LANE_W +: LANE_W]
- use_imm  in  1  replace every srcB lane with imm
- imm  in  LANE_W  broadcast immediate
- cmp_signed  in  1  signed V / signed MIN/MAX
- sat_mode  in  1  saturate ADD/SUB on signed overflow (requires cmp_signed)
- dbg_dryrun  in  1  force write_en to 0
- warp_id_i  in  WID_W  tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- alu_out  out  LANES*LANE_W  packed result
- write_en  out  LANES  commit mask
- Z, N, C, V  out  LANES  per-lane flags
- illegal_opcode  out  1  this result carried an illegal opcode
- err_sticky  out  1  set by any accepted illegal opcode
- err_clr  in  1  clears err_sticky
- warp_id_o  out  WID_W  tag of the result

Behaviour:
- Reset (rst_n=0 at posedge):
  - All outputs and stage-valid bits go to 0; in_ready reads 1 after reset.
  - Reset mid-operation discards in-flight instructions without emitting them.
- Handshake and pipeline:
  - adv = !out_valid | out_ready; in_ready = adv, as a global stall.
  - Transfer occurs when in_valid & in_ready.
  - Stage 1 registers the operands (imm mux applied), opcode, masks and tag.
  - Stage 2 computes and registers the results.
  - Latency is 2 cycles without stall; throughput is 1 instruction/cycle.
  - While stalled, all stage registers hold and the outputs stay stable.
  - A bubble, meaning stage 1 is invalid while adv is high, clears out_valid after it is accepted.
- Masks:
  - mask_eff = (mask_en ? lane_mask : all-ones) & pred.
  - write_en = dbg_dryrun ? 0 : mask_eff.
  - Masked-off lanes are still computed and flagged.
- Opcodes:
  - 0 ADD: C = carry out; V = signed overflow & cmp_signed.
  - 1 SUB: C = borrow (a<b unsigned); V as for ADD with the subtract rule.
  - ADD/SUB saturation: applies when sat_mode & cmp_signed & overflow. The result clamps to 0x7F..F if a is non-negative, else 0x80..0. V stays 1.
  - 2 NOT a.
  - 3 NAND.
  - 4 NOR.
  - 5 AND.
  - 6 OR.
  - 7 XOR.
  - 8 SHL, shift amount b[SH_W-1:0]. C = last bit shifted out; C=0 if the amount is 0.
  - 9 SHR, logical; C as for SHL.
  - A SRA, arithmetic; C as for SHL.
  - B MIN, C MAX: signed compare if cmp_signed, else unsigned.
  - D–F illegal: result 0 and illegal_opcode=1 for that result. C=V=0.
- Flags:
  - C and V are 0 for all ops except those listed above.
  - Z = (result==0) and N = result MSB, after saturation, for all ops including illegal.
- Errors:
  - illegal_opcode is per result, not sticky.
  - err_sticky sets when an illegal opcode is accepted at stage 1.
  - err_clr clears it; set wins when both occur in the same cycle.
- Boundaries:
  - SH_W bits cover shifts up to LANE_W-1; no larger shifts exist.
  - in_valid while in_ready=0 is ignored; the producer must hold its inputs.

Decomposition:
- Shared package simt_pkg:
  - opcode localparams (OP_ADD..OP_MAX, OP_ILLEGAL range)
  - flag index constants
- One sub-module, simt_lane_alu: combinational, parametrised by LANE_W.
  - Takes a, b, opcode, cmp_signed, sat_mode.
  - Produces r, z, n, c, v, illegal.
  - Instantiated LANES times via generate in stage 2.

Test Plan:
- LANES=4, LANE_W=8; ADD, srcA=0x7F01FF10, srcB=0x01010110, cmp_signed=1, sat_mode=1 -> out_valid 2 cycles later; alu_out=0x7F020020, V=4'b1000, C=4'b0010, Z=4'b0010, N=4'b0000.
- SUB, srcA=0x00000005, srcB=0x00000006, cmp_signed=0 -> lane0 result 0xFF, C[0]=1, N[0]=1, V=0.
- SRA use_imm=1, imm=0x01, srcA=0x80818203 -> alu_out=0xC0C0C101, C=4'b0101.
- MIN, srcA=0x80, srcB=0x01 per lane: cmp_signed=1 -> 0x80 per lane; cmp_signed=0 -> 0x01 per lane.
- Stream of 4 back-to-back instructions, out_ready=0 for 3 cycles after the first result -> in_ready=0 while stalled; outputs stable; all 4 results delivered in order with correct warp_id_o; none lost or duplicated.
- opcode=0xE, mask_en=1, lane_mask=4'b0110, pred=4'b0011, dbg_dryrun=0 -> illegal_opcode=1, alu_out=0, Z=4'hF, write_en=4'b0010, err_sticky=1 until err_clr. A second run with dbg_dryrun=1 -> write_en=0. Asserting rst_n=0 mid-stream -> out_valid=0 the next cycle.

Source files
------------

// File: rtl/simt_alu_pipe_pkg.sv
// Shared opcode encodings and flag indices for the SIMT lane ALU pipeline.
package simt_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_NOT  = 4'h2,
    OP_NAND = 4'h3,
    OP_NOR  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_SRA  = 4'hA,
    OP_MIN  = 4'hB,
    OP_MAX  = 4'hC
  } op_e;

  // Opcodes OP_ILLEGAL_LO..4'hF are reserved and produce an illegal result.
  localparam logic [3:0] OP_ILLEGAL_LO = 4'hD;

  localparam int unsigned FLAG_Z    = 0;
  localparam int unsigned FLAG_N    = 1;
  localparam int unsigned FLAG_C    = 2;
  localparam int unsigned FLAG_V    = 3;
  localparam int unsigned NUM_FLAGS = 4;

  function automatic logic is_illegal(input logic [3:0] op);
    return op >= OP_ILLEGAL_LO;
  endfunction

endpackage

// File: rtl/simt_lane_alu.sv
// Combinational single-lane ALU: arithmetic with optional signed saturation,
// logic ops, shifts with carry-out, and signed/unsigned MIN/MAX.
module simt_lane_alu
  import simt_pkg::*;
#(
  parameter int unsigned LANE_W = 8
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [3:0]        opcode,
  input  logic              cmp_signed,
  input  logic              sat_mode,
  output logic [LANE_W-1:0] r,
  output logic              z,
  output logic              n,
  output logic              c,
  output logic              v,
  output logic              illegal
);

  localparam int unsigned SH_W = $clog2(LANE_W);
  localparam logic [LANE_W-1:0] SMAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] SMIN = {1'b1, {(LANE_W-1){1'b0}}};

  logic [LANE_W:0]   sum;
  logic [LANE_W:0]   diff;
  logic [LANE_W:0]   shl_w;
  logic [LANE_W:0]   shr_w;
  logic [LANE_W:0]   sra_w;
  logic [SH_W-1:0]   sh;
  logic              add_ovf;
  logic              sub_ovf;
  logic              lt;

  always_comb begin
    sh      = b[SH_W-1:0];
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    add_ovf = (a[LANE_W-1] == b[LANE_W-1]) && (sum[LANE_W-1] != a[LANE_W-1]);
    sub_ovf = (a[LANE_W-1] != b[LANE_W-1]) && (diff[LANE_W-1] != a[LANE_W-1]);
    // One extra bit on the outgoing side captures the last bit shifted out;
    // a zero shift leaves that bit 0, giving C=0 without a special case.
    shl_w   = {1'b0, a} << sh;
    shr_w   = {a, 1'b0} >> sh;
    sra_w   = $unsigned($signed({a, 1'b0}) >>> sh);
    lt      = cmp_signed ? ($signed(a) < $signed(b)) : (a < b);

    r       = '0;
    c       = 1'b0;
    v       = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_ADD: begin
        r = sum[LANE_W-1:0];
        c = sum[LANE_W];
        v = add_ovf & cmp_signed;
        if (sat_mode && cmp_signed && add_ovf) r = a[LANE_W-1] ? SMIN : SMAX;
      end
      OP_SUB: begin
        r = diff[LANE_W-1:0];
        c = diff[LANE_W];
        v = sub_ovf & cmp_signed;
        if (sat_mode && cmp_signed && sub_ovf) r = a[LANE_W-1] ? SMIN : SMAX;
      end
      OP_NOT:  r = ~a;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SHL: begin
        r = shl_w[LANE_W-1:0];
        c = shl_w[LANE_W];
      end
      OP_SHR: begin
        r = shr_w[LANE_W:1];
        c = shr_w[0];
      end
      OP_SRA: begin
        r = sra_w[LANE_W:1];
        c = sra_w[0];
      end
      OP_MIN:  r = lt ? a : b;
      OP_MAX:  r = lt ? b : a;
      default: illegal = 1'b1;
    endcase
    z = (r == '0);
    n = r[LANE_W-1];
  end

endmodule

// File: rtl/simt_alu_pipe.sv
// Two-stage valid/ready SIMT ALU: stage 1 registers operands and masks,
// stage 2 computes all lanes and registers results, flags and commit mask.
module simt_alu_pipe
  import simt_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned WID_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               opcode,
  input  logic                     mask_en,
  input  logic [LANES-1:0]         lane_mask,
  input  logic [LANES-1:0]         pred,
  input  logic [LANES*LANE_W-1:0]  srcA,
  input  logic [LANES*LANE_W-1:0]  srcB,
  input  logic                     use_imm,
  input  logic [LANE_W-1:0]        imm,
  input  logic                     cmp_signed,
  input  logic                     sat_mode,
  input  logic                     dbg_dryrun,
  input  logic [WID_W-1:0]         warp_id_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*LANE_W-1:0]  alu_out,
  output logic [LANES-1:0]         write_en,
  output logic [LANES-1:0]         Z,
  output logic [LANES-1:0]         N,
  output logic [LANES-1:0]         C,
  output logic [LANES-1:0]         V,
  output logic                     illegal_opcode,
  output logic                     err_sticky,
  input  logic                     err_clr,
  output logic [WID_W-1:0]         warp_id_o
);

  logic                    adv;
  logic                    accept;

  logic                    s1_valid;
  logic [LANES*LANE_W-1:0] s1_a;
  logic [LANES*LANE_W-1:0] s1_b;
  logic [3:0]              s1_op;
  logic [LANES-1:0]        s1_mask;
  logic                    s1_dry;
  logic                    s1_cmp;
  logic                    s1_sat;
  logic [WID_W-1:0]        s1_wid;

  logic [LANES*LANE_W-1:0] res;
  logic [NUM_FLAGS-1:0]    lane_flags [LANES];
  logic [LANES-1:0]        lane_ill;
  logic [LANES-1:0]        fz, fn, fc, fv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    simt_lane_alu #(.LANE_W(LANE_W)) u_lane (
      .a          (s1_a[i*LANE_W +: LANE_W]),
      .b          (s1_b[i*LANE_W +: LANE_W]),
      .opcode     (s1_op),
      .cmp_signed (s1_cmp),
      .sat_mode   (s1_sat),
      .r          (res[i*LANE_W +: LANE_W]),
      .z          (lane_flags[i][FLAG_Z]),
      .n          (lane_flags[i][FLAG_N]),
      .c          (lane_flags[i][FLAG_C]),
      .v          (lane_flags[i][FLAG_V]),
      .illegal    (lane_ill[i])
    );
  end

  always_comb begin
    fz = '0;
    fn = '0;
    fc = '0;
    fv = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      fz[i] = lane_flags[i][FLAG_Z];
      fn[i] = lane_flags[i][FLAG_N];
      fc[i] = lane_flags[i][FLAG_C];
      fv[i] = lane_flags[i][FLAG_V];
    end
  end

  // Both stages advance together on adv; a stall freezes the whole pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid       <= 1'b0;
      s1_a           <= '0;
      s1_b           <= '0;
      s1_op          <= '0;
      s1_mask        <= '0;
      s1_dry         <= 1'b0;
      s1_cmp         <= 1'b0;
      s1_sat         <= 1'b0;
      s1_wid         <= '0;
      out_valid      <= 1'b0;
      alu_out        <= '0;
      write_en       <= '0;
      Z              <= '0;
      N              <= '0;
      C              <= '0;
      V              <= '0;
      illegal_opcode <= 1'b0;
      warp_id_o      <= '0;
      err_sticky     <= 1'b0;
    end else begin
      if (adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a    <= srcA;
          s1_b    <= use_imm ? {LANES{imm}} : srcB;
          s1_op   <= opcode;
          s1_mask <= (mask_en ? lane_mask : '1) & pred;
          s1_dry  <= dbg_dryrun;
          s1_cmp  <= cmp_signed;
          s1_sat  <= sat_mode;
          s1_wid  <= warp_id_i;
        end
        out_valid <= s1_valid;
        if (s1_valid) begin
          alu_out        <= res;
          write_en       <= s1_dry ? '0 : s1_mask;
          Z              <= fz;
          N              <= fn;
          C              <= fc;
          V              <= fv;
          illegal_opcode <= |lane_ill;
          warp_id_o      <= s1_wid;
        end
      end
      if (accept && is_illegal(opcode)) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_simt_alu_pipe.sv
// Directed vector bench for simt_alu_pipe (LANES=4, LANE_W=8).
module tb_simt_alu_pipe;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned WID_W  = 5;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              opcode;
  logic                    mask_en;
  logic [LANES-1:0]        lane_mask;
  logic [LANES-1:0]        pred;
  logic [LANES*LANE_W-1:0] srcA;
  logic [LANES*LANE_W-1:0] srcB;
  logic                    use_imm;
  logic [LANE_W-1:0]       imm;
  logic                    cmp_signed;
  logic                    sat_mode;
  logic                    dbg_dryrun;
  logic [WID_W-1:0]        warp_id_i;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*LANE_W-1:0] alu_out;
  logic [LANES-1:0]        write_en;
  logic [LANES-1:0]        Z, N, C, V;
  logic                    illegal_opcode;
  logic                    err_sticky;
  logic                    err_clr;
  logic [WID_W-1:0]        warp_id_o;

  simt_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W), .WID_W(WID_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .mask_en(mask_en), .lane_mask(lane_mask), .pred(pred),
    .srcA(srcA), .srcB(srcB), .use_imm(use_imm), .imm(imm),
    .cmp_signed(cmp_signed), .sat_mode(sat_mode), .dbg_dryrun(dbg_dryrun),
    .warp_id_i(warp_id_i), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .write_en(write_en), .Z(Z), .N(N), .C(C), .V(V),
    .illegal_opcode(illegal_opcode), .err_sticky(err_sticky),
    .err_clr(err_clr), .warp_id_o(warp_id_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        men;
    logic [3:0]  lm;
    logic [3:0]  pd;
    logic [31:0] a;
    logic [31:0] b;
    logic        ui;
    logic [7:0]  im;
    logic        cs;
    logic        sa;
    logic        dr;
    logic [31:0] eo;
    logic [3:0]  ew;
    logic [3:0]  ez;
    logic [3:0]  en;
    logic [3:0]  ec;
    logic [3:0]  ev;
    logic        ei;
  } vec_t;

  function automatic vec_t mk(
    input logic [3:0] op, input logic men, input logic [3:0] lm, input logic [3:0] pd,
    input logic [31:0] a, input logic [31:0] b, input logic ui, input logic [7:0] im,
    input logic cs, input logic sa, input logic dr, input logic [31:0] eo,
    input logic [3:0] ew, input logic [3:0] ez, input logic [3:0] en,
    input logic [3:0] ec, input logic [3:0] ev, input logic ei);
    vec_t v;
    v.op = op; v.men = men; v.lm = lm; v.pd = pd; v.a = a; v.b = b;
    v.ui = ui; v.im = im; v.cs = cs; v.sa = sa; v.dr = dr; v.eo = eo;
    v.ew = ew; v.ez = ez; v.en = en; v.ec = ec; v.ev = ev; v.ei = ei;
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; opcode = 0; mask_en = 0; lane_mask = '0; pred = '1;
    srcA = '0; srcB = '0; use_imm = 0; imm = '0; cmp_signed = 0;
    sat_mode = 0; dbg_dryrun = 0; warp_id_i = '0; err_clr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    logic exp_sticky;
    int   lat;
    int   sent, got, stall_left;
    bit   first_seen, prev_stalled, acc, seen_valid;
    logic [31:0] prev_out;
    logic [WID_W-1:0] prev_wid;

    //              op  men lm    pd    a             b             ui im     cs sa dr  eo            ew    ez    en    ec    ev    ei
    vecs.push_back(mk(4'h0,0,4'h0,4'hF,32'h7F01FF10,32'h01010110,0,8'h00,1,1,0,32'h7F020020,4'hF,4'h2,4'h0,4'h2,4'h8,0));
    vecs.push_back(mk(4'h1,0,4'h0,4'hF,32'h00000005,32'h00000006,0,8'h00,0,0,0,32'h000000FF,4'hF,4'hE,4'h1,4'h1,4'h0,0));
    vecs.push_back(mk(4'hA,0,4'h0,4'hF,32'h80818203,32'hFFFFFFFF,1,8'h01,0,0,0,32'hC0C0C101,4'hF,4'h0,4'hE,4'h5,4'h0,0));
    vecs.push_back(mk(4'hB,0,4'h0,4'hF,32'h80808080,32'h01010101,0,8'h00,1,0,0,32'h80808080,4'hF,4'h0,4'hF,4'h0,4'h0,0));
    vecs.push_back(mk(4'hB,0,4'h0,4'hF,32'h80808080,32'h01010101,0,8'h00,0,0,0,32'h01010101,4'hF,4'h0,4'h0,4'h0,4'h0,0));
    vecs.push_back(mk(4'h7,1,4'hA,4'hF,32'hFF00F0AA,32'h0F0FF055,0,8'h00,0,0,0,32'hF00F00FF,4'hA,4'h2,4'h9,4'h0,4'h0,0));
    vecs.push_back(mk(4'h8,0,4'h0,4'h7,32'h814001FF,32'h01010007,0,8'h00,0,0,0,32'h02800180,4'h7,4'h0,4'h5,4'h9,4'h0,0));
    vecs.push_back(mk(4'h9,0,4'h0,4'hF,32'h818001FF,32'h01070004,0,8'h00,0,0,0,32'h4001010F,4'hF,4'h0,4'h0,4'h9,4'h0,0));
    vecs.push_back(mk(4'hC,0,4'h0,4'hF,32'h807F05FE,32'h018005FF,0,8'h00,1,0,0,32'h017F05FF,4'hF,4'h0,4'h1,4'h0,4'h0,0));
    vecs.push_back(mk(4'h1,0,4'h0,4'hF,32'h807F0010,32'h01FF0110,0,8'h00,1,1,0,32'h807FFF00,4'hF,4'h1,4'hA,4'h6,4'hC,0));
    vecs.push_back(mk(4'h0,0,4'h0,4'hF,32'h7F000000,32'h01000000,0,8'h00,1,0,0,32'h80000000,4'hF,4'h7,4'h8,4'h0,4'h8,0));
    vecs.push_back(mk(4'h3,0,4'h0,4'hF,32'hFFF000AA,32'hFF0F0055,0,8'h00,0,0,0,32'h00FFFFFF,4'hF,4'h8,4'h7,4'h0,4'h0,0));
    vecs.push_back(mk(4'h2,0,4'h0,4'hF,32'hFF000F80,32'h00000000,0,8'h00,0,0,0,32'h00FFF07F,4'hF,4'h8,4'h6,4'h0,4'h0,0));
    vecs.push_back(mk(4'h4,0,4'h0,4'hF,32'h0F00F0AA,32'hF0000055,0,8'h00,0,0,0,32'h00FF0F00,4'hF,4'h9,4'h4,4'h0,4'h0,0));
    vecs.push_back(mk(4'h5,0,4'h0,4'hF,32'hFFF0AA00,32'h0FFF5500,0,8'h00,0,0,0,32'h0FF00000,4'hF,4'h3,4'h4,4'h0,4'h0,0));
    vecs.push_back(mk(4'h6,0,4'h0,4'hF,32'hF0000180,32'h0F000200,0,8'h00,0,0,0,32'hFF000380,4'hF,4'h4,4'h9,4'h0,4'h0,0));
    vecs.push_back(mk(4'hE,1,4'h6,4'h3,32'h12345678,32'h9ABCDEF0,0,8'h00,1,1,0,32'h00000000,4'h2,4'hF,4'h0,4'h0,4'h0,1));
    vecs.push_back(mk(4'hE,1,4'h6,4'h3,32'h12345678,32'h9ABCDEF0,0,8'h00,1,1,1,32'h00000000,4'h0,4'hF,4'h0,4'h0,4'h0,1));
    vecs.push_back(mk(4'hD,0,4'h0,4'hF,32'hFFFFFFFF,32'h01010101,0,8'h00,0,0,0,32'h00000000,4'hF,4'hF,4'h0,4'h0,4'h0,1));
    vecs.push_back(mk(4'hF,0,4'h0,4'hF,32'h7F7F7F7F,32'h01010101,0,8'h00,1,1,0,32'h00000000,4'hF,4'hF,4'h0,4'h0,4'h0,1));

    idle_inputs();
    out_ready = 1;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    rst_n = 1;
    @(posedge clk); #1;

    exp_sticky = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      string nm;
      v = vecs[i];
      nm = $sformatf("v%0d", i);
      opcode = v.op; mask_en = v.men; lane_mask = v.lm; pred = v.pd;
      srcA = v.a; srcB = v.b; use_imm = v.ui; imm = v.im;
      cmp_signed = v.cs; sat_mode = v.sa; dbg_dryrun = v.dr;
      warp_id_i = 5'(i);
      in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      lat = 0;
      while (!out_valid && lat < 6) begin
        @(posedge clk); #1;
        lat++;
      end
      chk({nm, "_latency"}, 32'(lat), 32'd1);
      chk({nm, "_alu_out"}, alu_out, v.eo);
      chk({nm, "_write_en"}, 32'(write_en), 32'(v.ew));
      chk({nm, "_Z"}, 32'(Z), 32'(v.ez));
      chk({nm, "_N"}, 32'(N), 32'(v.en));
      chk({nm, "_C"}, 32'(C), 32'(v.ec));
      chk({nm, "_V"}, 32'(V), 32'(v.ev));
      chk({nm, "_illegal"}, 32'(illegal_opcode), 32'(v.ei));
      chk({nm, "_warp_id"}, 32'(warp_id_o), i);
      if (v.ei) exp_sticky = 1;
      chk({nm, "_err_sticky"}, 32'(err_sticky), 32'(exp_sticky));
      @(posedge clk); #1;
      chk({nm, "_bubble"}, 32'(out_valid), 32'd0);
    end

    // sticky error: holds, clears, and set wins over a same-cycle clear
    repeat (3) @(posedge clk);
    #1;
    chk("sticky_hold", 32'(err_sticky), 32'd1);
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    chk("sticky_clear", 32'(err_sticky), 32'd0);
    opcode = 4'hE; in_valid = 1; err_clr = 1;
    @(posedge clk); #1;
    in_valid = 0; err_clr = 0;
    chk("sticky_set_wins", 32'(err_sticky), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    chk("sticky_clear2", 32'(err_sticky), 32'd0);

    // back-to-back stream with a 3-cycle output stall after the first result
    idle_inputs();
    sent = 0; got = 0; stall_left = 0; first_seen = 0; prev_stalled = 0;
    prev_out = '0; prev_wid = '0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      in_valid  = (sent < 4);
      srcA      = {4{8'(sent + 1)}};
      srcB      = {4{8'h10}};
      warp_id_i = 5'(sent + 3);
      if (stall_left > 0) begin
        out_ready = 0;
        stall_left--;
      end else begin
        out_ready = 1;
      end
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk($sformatf("stream%0d_out", got), alu_out, {4{8'(got + 17)}});
        chk($sformatf("stream%0d_wid", got), 32'(warp_id_o), 32'(got + 3));
        got++;
        if (!first_seen) begin
          first_seen = 1;
          stall_left = 3;
        end
        prev_stalled = 0;
      end else if (out_valid) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        if (prev_stalled) begin
          chk("stall_out_stable", alu_out, prev_out);
          chk("stall_wid_stable", 32'(warp_id_o), 32'(prev_wid));
        end
        prev_stalled = 1;
        prev_out = alu_out;
        prev_wid = warp_id_o;
      end else begin
        prev_stalled = 0;
      end
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 0;
    out_ready = 1;
    chk("stream_count", 32'(got), 32'd4);
    chk("stream_sent", 32'(sent), 32'd4);
    #1;
    chk("stream_no_dup", 32'(out_valid), 32'd0);

    // reset while two instructions are in flight
    opcode = 4'hE; in_valid = 1; warp_id_i = 5'd9;
    @(posedge clk); #1;
    opcode = 4'h0; warp_id_i = 5'd10;
    @(posedge clk); #1;
    in_valid = 0;
    chk("midrst_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sticky", 32'(err_sticky), 32'd0);
    chk("midrst_illegal", 32'(illegal_opcode), 32'd0);
    rst_n = 1;
    seen_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1;
    end
    chk("midrst_discard", 32'(seen_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
